// File: rtl/axi_ni_target_request_decoder_pkg.sv
// Shared field widths, NoC/AXI code points and FSM types for the target-side
// request decoder.
package axi_ni_target_request_decoder_pkg;

  localparam int PACKET_COMMAND_W      = 4;
  localparam int PACKET_ADDRESS_W      = 32;
  localparam int PACKET_BURST_LENGTH_W = 9;
  localparam int PACKET_BURST_INCR_W   = 3;
  localparam int PACKET_BURST_SEQ_W    = 2;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;

  localparam logic [PACKET_COMMAND_W-1:0] PACKET_CMD_READ = 4'h1;
  localparam logic [PACKET_COMMAND_W-1:0] PACKET_CMD_WRNP = 4'h2;
  localparam logic [PACKET_COMMAND_W-1:0] PACKET_CMD_WR   = 4'h3;

  localparam logic [PACKET_BURST_SEQ_W-1:0] PACKET_SEQ_STRM = 2'd0;
  localparam logic [PACKET_BURST_SEQ_W-1:0] PACKET_SEQ_INCR = 2'd1;
  localparam logic [PACKET_BURST_SEQ_W-1:0] PACKET_SEQ_WRAP = 2'd2;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR_RD,
    ST_ADDR_WR,
    ST_WDATA
  } state_t;

  typedef enum logic [1:0] {
    CMD_CLASS_DROP,
    CMD_CLASS_READ,
    CMD_CLASS_WRITE
  } cmd_class_t;

  function automatic cmd_class_t classify_cmd(input logic [PACKET_COMMAND_W-1:0] cmd);
    if (cmd == PACKET_CMD_READ) return CMD_CLASS_READ;
    if (cmd == PACKET_CMD_WRNP || cmd == PACKET_CMD_WR) return CMD_CLASS_WRITE;
    return CMD_CLASS_DROP;
  endfunction

endpackage

// File: rtl/axi_ni_target_request_decoder_burst_map.sv
// Combinational translation of packet burst fields to AXI axburst/axsize/axlen,
// plus a flag saying whether the burst can be expressed on this AXI port.
module axi_ni_target_request_decoder_burst_map
  import axi_ni_target_request_decoder_pkg::*;
#(
  parameter int AXIWDATAWD = 32
) (
  input  logic [PACKET_BURST_SEQ_W-1:0]    burst_seq,
  input  logic [PACKET_BURST_INCR_W-1:0]   burst_incr,
  input  logic [PACKET_BURST_LENGTH_W-1:0] burst_length,
  output logic [AXI_BURST_W-1:0]           axburst,
  output logic [AXI_SIZE_W-1:0]            axsize,
  output logic [AXI_LEN_W-1:0]             axlen,
  output logic                             legal
);

  localparam int MAX_SIZE = $clog2(AXIWDATAWD / 8);

  always_comb begin
    axburst = AXI_BURST_INCR;
    case (burst_seq)
      PACKET_SEQ_STRM: axburst = AXI_BURST_FIXED;
      PACKET_SEQ_INCR: axburst = AXI_BURST_INCR;
      PACKET_SEQ_WRAP: axburst = AXI_BURST_WRAP;
      default:         axburst = AXI_BURST_INCR;
    endcase
  end

  assign axsize = AXI_SIZE_W'(burst_incr);
  assign axlen  = AXI_LEN_W'(burst_length - PACKET_BURST_LENGTH_W'(1));

  // Beat size may not exceed the data bus; length must fit the AXI len field.
  assign legal = (burst_length != '0)
              && (int'(burst_length) <= (1 << AXI_LEN_W))
              && (int'(burst_incr) <= MAX_SIZE);

endmodule

// File: rtl/axi_ni_target_request_decoder.sv
// Target-side NI: converts one depacketized NoC request header at a time into
// an AXI AR, or AW followed by its W burst with generated WLAST.
module axi_ni_target_request_decoder
  import axi_ni_target_request_decoder_pkg::*;
#(
  parameter int FLIT_WIDTH  = 32,
  parameter int AXIWDATAWD  = 32,
  parameter int AXIARADDRWD = 32,
  parameter int AXIAWADDRWD = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [PACKET_COMMAND_W-1:0]      req_command,
  input  logic [PACKET_ADDRESS_W-1:0]      req_address,
  input  logic [PACKET_BURST_LENGTH_W-1:0] req_burst_length,
  input  logic [PACKET_BURST_INCR_W-1:0]   req_burst_incr,
  input  logic [PACKET_BURST_SEQ_W-1:0]    req_burst_seq,
  input  logic [AXIWDATAWD-1:0]            pkt_wdata,
  input  logic [AXIWDATAWD/8-1:0]          pkt_wstrb,
  input  logic                             pkt_wvalid,
  output logic                             pkt_wready,
  output logic [AXIAWADDRWD-1:0]           awaddr,
  output logic [AXI_LEN_W-1:0]             awlen,
  output logic [AXI_SIZE_W-1:0]            awsize,
  output logic [AXI_BURST_W-1:0]           awburst,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [AXIARADDRWD-1:0]           araddr,
  output logic [AXI_LEN_W-1:0]             arlen,
  output logic [AXI_SIZE_W-1:0]            arsize,
  output logic [AXI_BURST_W-1:0]           arburst,
  output logic                             arvalid,
  input  logic                             arready,
  output logic [AXIWDATAWD-1:0]            wdata,
  output logic [AXIWDATAWD/8-1:0]          wstrb,
  output logic                             wlast,
  output logic                             wvalid,
  input  logic                             wready,
  output logic                             err_unsupported
);

  if (AXIWDATAWD % 8 != 0 || FLIT_WIDTH < PACKET_COMMAND_W) begin : g_param_check
    $error("axi_ni_target_request_decoder: unsupported width parameters");
  end

  state_t                           state, next_state;
  logic [PACKET_ADDRESS_W-1:0]      addr_q;
  logic [AXI_LEN_W-1:0]             len_q;
  logic [AXI_SIZE_W-1:0]            size_q;
  logic [AXI_BURST_W-1:0]           burst_q;
  logic [PACKET_BURST_LENGTH_W-1:0] cnt_q;
  logic                             err_q;

  logic [AXI_BURST_W-1:0] map_burst;
  logic [AXI_SIZE_W-1:0]  map_size;
  logic [AXI_LEN_W-1:0]   map_len;
  logic                   map_legal;
  cmd_class_t             cmd_class;
  logic                   load_hdr, load_cnt, dec_cnt, drop;

  axi_ni_target_request_decoder_burst_map #(
    .AXIWDATAWD(AXIWDATAWD)
  ) u_burst_map (
    .burst_seq   (req_burst_seq),
    .burst_incr  (req_burst_incr),
    .burst_length(req_burst_length),
    .axburst     (map_burst),
    .axsize      (map_size),
    .axlen       (map_len),
    .legal       (map_legal)
  );

  assign cmd_class = classify_cmd(req_command);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    load_hdr   = 1'b0;
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (map_legal && cmd_class == CMD_CLASS_READ) begin
            next_state = ST_ADDR_RD;
            load_hdr   = 1'b1;
          end else if (map_legal && cmd_class == CMD_CLASS_WRITE) begin
            next_state = ST_ADDR_WR;
            load_hdr   = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_ADDR_RD: if (arready) next_state = ST_IDLE;
      ST_ADDR_WR: begin
        if (awready) begin
          next_state = ST_WDATA;
          load_cnt   = 1'b1;
        end
      end
      ST_WDATA: begin
        if (pkt_wvalid && wready) begin
          dec_cnt = 1'b1;
          if (cnt_q == PACKET_BURST_LENGTH_W'(1)) next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (load_hdr) begin
        addr_q  <= req_address;
        len_q   <= map_len;
        size_q  <= map_size;
        burst_q <= map_burst;
      end
      if (load_cnt)     cnt_q <= PACKET_BURST_LENGTH_W'(len_q) + PACKET_BURST_LENGTH_W'(1);
      else if (dec_cnt) cnt_q <= cnt_q - PACKET_BURST_LENGTH_W'(1);
      err_q <= drop;
    end
  end

  // AR and AW share one header register set; the valids say which is live.
  assign araddr  = AXIARADDRWD'(addr_q);
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = burst_q;
  assign arvalid = (state == ST_ADDR_RD);

  assign awaddr  = AXIAWADDRWD'(addr_q);
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = burst_q;
  assign awvalid = (state == ST_ADDR_WR);

  assign wdata      = pkt_wdata;
  assign wstrb      = pkt_wstrb;
  assign wvalid     = (state == ST_WDATA) && pkt_wvalid;
  assign pkt_wready = (state == ST_WDATA) && wready;
  assign wlast      = wvalid && (cnt_q == PACKET_BURST_LENGTH_W'(1));

  assign err_unsupported = err_q;

endmodule

// File: tb/tb_axi_ni_target_request_decoder.sv
// Directed self-checking bench for axi_ni_target_request_decoder.
module tb_axi_ni_target_request_decoder;
  import axi_ni_target_request_decoder_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst_n;
  logic                             req_valid;
  logic                             req_ready;
  logic [PACKET_COMMAND_W-1:0]      req_command;
  logic [PACKET_ADDRESS_W-1:0]      req_address;
  logic [PACKET_BURST_LENGTH_W-1:0] req_burst_length;
  logic [PACKET_BURST_INCR_W-1:0]   req_burst_incr;
  logic [PACKET_BURST_SEQ_W-1:0]    req_burst_seq;
  logic [31:0]                      pkt_wdata;
  logic [3:0]                       pkt_wstrb;
  logic                             pkt_wvalid;
  logic                             pkt_wready;
  logic [31:0]                      awaddr;
  logic [AXI_LEN_W-1:0]             awlen;
  logic [AXI_SIZE_W-1:0]            awsize;
  logic [AXI_BURST_W-1:0]           awburst;
  logic                             awvalid;
  logic                             awready;
  logic [31:0]                      araddr;
  logic [AXI_LEN_W-1:0]             arlen;
  logic [AXI_SIZE_W-1:0]            arsize;
  logic [AXI_BURST_W-1:0]           arburst;
  logic                             arvalid;
  logic                             arready;
  logic [31:0]                      wdata;
  logic [3:0]                       wstrb;
  logic                             wlast;
  logic                             wvalid;
  logic                             wready;
  logic                             err_unsupported;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_ni_target_request_decoder #(
    .FLIT_WIDTH(32), .AXIWDATAWD(32), .AXIARADDRWD(32), .AXIAWADDRWD(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command),
    .req_address(req_address), .req_burst_length(req_burst_length),
    .req_burst_incr(req_burst_incr), .req_burst_seq(req_burst_seq),
    .pkt_wdata(pkt_wdata), .pkt_wstrb(pkt_wstrb), .pkt_wvalid(pkt_wvalid), .pkt_wready(pkt_wready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .err_unsupported(err_unsupported)
  );

  task automatic set_hdr(input logic [3:0] cmd, input logic [31:0] addr, input int len,
                         input int incr, input logic [1:0] seq);
    req_command      = cmd;
    req_address      = addr;
    req_burst_length = PACKET_BURST_LENGTH_W'(len);
    req_burst_incr   = PACKET_BURST_INCR_W'(incr);
    req_burst_seq    = seq;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 0; pkt_wvalid = 0; pkt_wdata = '0; pkt_wstrb = '0;
    awready = 0; arready = 0; wready = 0;
    set_hdr(4'h0, 32'h0, 0, 0, 2'd0);
    step(); step();
    vectors++; if ({arvalid, awvalid, wvalid, wlast, err_unsupported, pkt_wready} !== 6'b0) begin
      miscompares++; $display("FAIL reset_valids got %b exp 000000", {arvalid, awvalid, wvalid, wlast, err_unsupported, pkt_wready});
    end
    vectors++; if ({araddr, arlen, arsize, arburst} !== '0) begin
      miscompares++; $display("FAIL reset_regs got %h/%h/%h/%h exp 0", araddr, arlen, arsize, arburst);
    end
    vectors++; if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_req_ready got %b exp 1", req_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read(input logic [31:0] addr, input int len, input int incr, input logic [1:0] seq,
                           input logic [7:0] exp_len, input logic [1:0] exp_burst, input int wait_cyc);
    int hold = 0; int hs = 0; int aw_seen = 0;
    set_hdr(PACKET_CMD_READ, addr, len, incr, seq);
    req_valid = 1'b1;
    vectors++; if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL read_req_ready got %b exp 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    for (int i = 0; i < wait_cyc + 4; i++) begin
      if (awvalid) aw_seen++;
      if (arvalid) begin
        hold++;
        vectors++; if ({araddr, arlen, arsize, arburst} !== {addr, exp_len, 3'(incr), exp_burst}) begin
          miscompares++; $display("FAIL read_fields got %h/%h/%h/%h exp %h/%h/%h/%h", araddr, arlen, arsize, arburst, addr, exp_len, 3'(incr), exp_burst);
        end
      end
      arready = (i == wait_cyc - 1);
      if (arvalid && arready) hs++;
      step();
    end
    arready = 1'b0;
    vectors++; if (hold !== wait_cyc || hs !== 1) begin
      miscompares++; $display("FAIL read_hold got %0d cycles/%0d handshakes exp %0d/1", hold, hs, wait_cyc);
    end
    vectors++; if (aw_seen !== 0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL read_idle got aw_seen=%0d req_ready=%b exp 0/1", aw_seen, req_ready);
    end
  endtask

  task automatic test_write(input logic [3:0] cmd, input logic [31:0] addr, input int len, input logic [1:0] seq,
                            input logic [7:0] exp_len, input logic [1:0] exp_burst, input logic [15:0] stall);
    int beats = 0;
    set_hdr(cmd, addr, len, 2, seq);
    req_valid = 1'b1; awready = 1'b0; pkt_wvalid = 1'b1; wready = 1'b1; pkt_wstrb = 4'hF;
    pkt_wdata = 32'hDEAD_0000;
    step();
    req_valid = 1'b0;
    vectors++; if ({awvalid, awaddr, awlen, awsize, awburst} !== {1'b1, addr, exp_len, 3'd2, exp_burst}) begin
      miscompares++; $display("FAIL write_aw got %b/%h/%h/%h/%h exp 1/%h/%h/2/%h", awvalid, awaddr, awlen, awsize, awburst, addr, exp_len, exp_burst);
    end
    vectors++; if ({wvalid, pkt_wready, arvalid} !== 3'b000) begin
      miscompares++; $display("FAIL write_w_before_aw got %b exp 000", {wvalid, pkt_wready, arvalid});
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    for (int i = 0; i < 24 && beats < len; i++) begin
      wready = stall[i];
      pkt_wdata = 32'hA500_0000 | 32'(beats);
      #1;
      vectors++; if ({wvalid, wdata, wstrb, wlast, pkt_wready} !== {1'b1, 32'hA500_0000 | 32'(beats), 4'hF, (beats == len - 1), stall[i]}) begin
        miscompares++; $display("FAIL write_beat%0d got v=%b d=%h s=%h last=%b rdy=%b exp v=1 d=%h s=f last=%b rdy=%b", beats, wvalid, wdata, wstrb, wlast, pkt_wready, 32'hA500_0000 | 32'(beats), (beats == len - 1), stall[i]);
      end
      if (stall[i]) beats++;
      step();
    end
    vectors++; if (beats !== len || req_ready !== 1'b1 || wvalid !== 1'b0 || pkt_wready !== 1'b0) begin
      miscompares++; $display("FAIL write_done got beats=%0d req_ready=%b wvalid=%b pkt_wready=%b exp %0d/1/0/0", beats, req_ready, wvalid, pkt_wready, len);
    end
    pkt_wvalid = 1'b0; wready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [3:0] cmds [4] = '{PACKET_CMD_READ, PACKET_CMD_READ, PACKET_CMD_WRNP, 4'hF};
    int lens [4] = '{0, 1, 257, 1};
    int incrs [4] = '{2, 3, 0, 0};
    for (int k = 0; k < 4; k++) begin
      set_hdr(cmds[k], 32'h3000, lens[k], incrs[k], PACKET_SEQ_INCR);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      vectors++; if ({err_unsupported, arvalid, awvalid, req_ready} !== 4'b1001) begin
        miscompares++; $display("FAIL illegal%0d_pulse got err/ar/aw/rdy=%b exp 1001", k, {err_unsupported, arvalid, awvalid, req_ready});
      end
      step();
      vectors++; if ({err_unsupported, arvalid, awvalid, req_ready} !== 4'b0001) begin
        miscompares++; $display("FAIL illegal%0d_after got err/ar/aw/rdy=%b exp 0001", k, {err_unsupported, arvalid, awvalid, req_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    int wlast_cyc = -1; int ar_cyc = -1; int drop = 0;
    set_hdr(PACKET_CMD_WR, 32'h4000, 2, 2, PACKET_SEQ_INCR);
    req_valid = 1'b1; awready = 1'b1; wready = 1'b1; pkt_wvalid = 1'b1; pkt_wstrb = 4'h3; pkt_wdata = 32'h1234_5678;
    step();
    set_hdr(PACKET_CMD_READ, 32'h5000, 2, 1, PACKET_SEQ_STRM);
    for (int i = 0; i < 16; i++) begin
      if (wvalid && wready && wlast) wlast_cyc = i;
      if (arvalid && ar_cyc < 0) ar_cyc = i;
      if (req_valid && req_ready) begin
        vectors++; if (wlast_cyc < 0) begin
          miscompares++; $display("FAIL b2b_early_accept got accept at %0d exp after wlast", i);
        end
        drop = 1;
      end
      step();
      if (drop != 0) req_valid = 1'b0;
    end
    awready = 1'b0; pkt_wvalid = 1'b0; wready = 1'b0;
    vectors++; if (wlast_cyc !== 2 || ar_cyc !== 4) begin
      miscompares++; $display("FAIL b2b_timing got wlast@%0d ar@%0d exp 2/4", wlast_cyc, ar_cyc);
    end
    vectors++; if ({arvalid, araddr, arlen, arsize, arburst} !== {1'b1, 32'h5000, 8'd1, 3'd1, AXI_BURST_FIXED}) begin
      miscompares++; $display("FAIL b2b_read_fields got %b/%h/%h/%h/%h exp 1/5000/01/1/0", arvalid, araddr, arlen, arsize, arburst);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_hdr(PACKET_CMD_WRNP, 32'h6000, 4, 2, PACKET_SEQ_INCR);
    req_valid = 1'b1; awready = 1'b1; wready = 1'b1; pkt_wvalid = 1'b1; pkt_wstrb = 4'hF;
    step();
    req_valid = 1'b0;
    step();
    awready = 1'b0;
    step();
    #1;
    vectors++; if ({wvalid, pkt_wready, wlast} !== 3'b110) begin
      miscompares++; $display("FAIL midreset_pre got wvalid/pkt_wready/wlast=%b exp 110", {wvalid, pkt_wready, wlast});
    end
    rst_n = 1'b0;
    #1;
    vectors++; if ({wvalid, pkt_wready, wlast, awvalid, arvalid, err_unsupported} !== 6'b0) begin
      miscompares++; $display("FAIL midreset_async got %b exp 000000", {wvalid, pkt_wready, wlast, awvalid, arvalid, err_unsupported});
    end
    vectors++; if ({awaddr, awlen} !== '0) begin
      miscompares++; $display("FAIL midreset_regs got %h/%h exp 0/0", awaddr, awlen);
    end
    pkt_wvalid = 1'b0; wready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_read(32'h1000, 4, 2, PACKET_SEQ_INCR, 8'd3, AXI_BURST_INCR, 3);
    test_write(PACKET_CMD_WRNP, 32'h2000, 3, PACKET_SEQ_WRAP, 8'd2, AXI_BURST_WRAP, 16'h001A);
    test_write(PACKET_CMD_WR, 32'h2100, 1, PACKET_SEQ_STRM, 8'd0, AXI_BURST_FIXED, 16'h0001);
    test_illegal();
    test_read(32'h1200, 256, 2, 2'd3, 8'd255, AXI_BURST_INCR, 1);
    test_back_to_back();
    test_reset_mid();
    test_read(32'h7000, 2, 0, PACKET_SEQ_WRAP, 8'd1, AXI_BURST_WRAP, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
